// File: rtl/pipe_pkg.sv
// Shared pipeline types for the hazard controller: stage bookkeeping entries and
// operand-forward select encodings.
package pipe_pkg;

  localparam int unsigned PIPE_REG_W = 5;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

  typedef struct packed {
    logic                  vld;
    logic [PIPE_REG_W-1:0] rd;
    logic                  wr;
    logic                  ld;
  } stage_entry_t;

  // Register 0 is hardwired, so when r0_zero is set it never produces a hazard.
  function automatic logic stage_match(stage_entry_t e, logic [PIPE_REG_W-1:0] r,
                                       logic r0_zero);
    return e.vld & e.wr & (e.rd == r) & ~(r0_zero & (r == '0));
  endfunction

endpackage

// File: rtl/hazard_controller_if.sv
// Decode-side hazard bus: decode operand/destination info in, sequencing controls,
// forwarding selects and counters out.
interface hazard_controller_if #(
  parameter int unsigned REG_W = 5,
  parameter int unsigned CNT_W = 16
);
  logic [REG_W-1:0] RaD;
  logic [REG_W-1:0] RbD;
  logic             UseAD;
  logic             UseBD;
  logic [REG_W-1:0] RwD;
  logic             RegWrD;
  logic             LoadD;
  logic             JumpD;
  logic             BranchTakenE;
  logic             IdValid;
  logic             PcHold;
  logic             IrHold;
  logic             BubbleE;
  logic             FlushIF;
  logic             FlushID;
  logic [1:0]       FwdA;
  logic [1:0]       FwdB;
  logic [CNT_W-1:0] StallCnt;
  logic [CNT_W-1:0] FlushCnt;

  modport master (
    output RaD, RbD, UseAD, UseBD, RwD, RegWrD, LoadD, JumpD, BranchTakenE,
    input  IdValid, PcHold, IrHold, BubbleE, FlushIF, FlushID, FwdA, FwdB, StallCnt, FlushCnt
  );

  modport slave (
    input  RaD, RbD, UseAD, UseBD, RwD, RegWrD, LoadD, JumpD, BranchTakenE,
    output IdValid, PcHold, IrHold, BubbleE, FlushIF, FlushID, FwdA, FwdB, StallCnt, FlushCnt
  );
endinterface

// File: rtl/fwd_select.sv
// Priority forward select for one decode source: youngest in-flight writer wins.
module fwd_select
  import pipe_pkg::*;
#(
  parameter bit R0_ZERO = 1'b1
) (
  input  logic [PIPE_REG_W-1:0] src_i,
  input  logic                  use_i,
  input  stage_entry_t          ex_i,
  input  stage_entry_t          mem_i,
  input  stage_entry_t          wb_i,
  output logic [1:0]            sel_o
);

  always_comb begin
    sel_o = FWD_RF;
    if (use_i) begin
      if (stage_match(ex_i, src_i, R0_ZERO)) begin
        sel_o = FWD_EX;
      end else if (stage_match(mem_i, src_i, R0_ZERO)) begin
        sel_o = FWD_MEM;
      end else if (stage_match(wb_i, src_i, R0_ZERO)) begin
        sel_o = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// 5-stage pipeline hazard controller: load-use stall, control-transfer flush,
// decode forwarding selects and saturating stall/flush counters.
module hazard_controller
  import pipe_pkg::*;
#(
  parameter int unsigned REG_W   = PIPE_REG_W,
  parameter int unsigned CNT_W   = 16,
  parameter bit          R0_ZERO = 1'b1
) (
  input logic               clk,
  input logic               rst_n,
  hazard_controller_if.slave bus
);

  logic         id_vld_q, id_vld_d;
  stage_entry_t ex_q, ex_d, mem_q, wb_q;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic       load_use, stall, flush_if, flush_id, bubble;
  logic [1:0] fwd_a_raw, fwd_b_raw;

  fwd_select #(.R0_ZERO(R0_ZERO)) u_fwd_a (
    .src_i (bus.RaD),
    .use_i (bus.UseAD),
    .ex_i  (ex_q),
    .mem_i (mem_q),
    .wb_i  (wb_q),
    .sel_o (fwd_a_raw)
  );

  fwd_select #(.R0_ZERO(R0_ZERO)) u_fwd_b (
    .src_i (bus.RbD),
    .use_i (bus.UseBD),
    .ex_i  (ex_q),
    .mem_i (mem_q),
    .wb_i  (wb_q),
    .sel_o (fwd_b_raw)
  );

  // A taken branch kills the dependent instruction, so it overrides the stall.
  always_comb begin
    load_use = id_vld_q & ex_q.ld &
               ((bus.UseAD & stage_match(ex_q, bus.RaD, R0_ZERO)) |
                (bus.UseBD & stage_match(ex_q, bus.RbD, R0_ZERO)));
    stall    = load_use & ~bus.BranchTakenE;
    flush_id = bus.BranchTakenE;
    flush_if = bus.BranchTakenE | (id_vld_q & bus.JumpD & ~stall);
    bubble   = stall | flush_id;
  end

  always_comb begin
    ex_d = '0;
    if (!bubble) begin
      ex_d.vld = id_vld_q;
      ex_d.rd  = bus.RwD;
      ex_d.wr  = bus.RegWrD;
      ex_d.ld  = bus.LoadD;
    end

    if (stall) begin
      id_vld_d = id_vld_q;
    end else if (flush_if) begin
      id_vld_d = 1'b0;
    end else begin
      id_vld_d = 1'b1;
    end

    stall_cnt_d = stall_cnt_q;
    if (stall && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    flush_cnt_d = flush_cnt_q;
    if (flush_if && !(&flush_cnt_q)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_vld_q    <= 1'b0;
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      id_vld_q    <= id_vld_d;
      ex_q        <= ex_d;
      mem_q       <= ex_q;
      wb_q        <= mem_q;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Every output is held low while reset is asserted, even if inputs are active.
  always_comb begin
    bus.IdValid  = rst_n & id_vld_q;
    bus.PcHold   = rst_n & stall;
    bus.IrHold   = rst_n & stall;
    bus.BubbleE  = rst_n & bubble;
    bus.FlushIF  = rst_n & flush_if;
    bus.FlushID  = rst_n & flush_id;
    bus.FwdA     = (rst_n & id_vld_q & ~stall) ? fwd_a_raw : FWD_RF;
    bus.FwdB     = (rst_n & id_vld_q & ~stall) ? fwd_b_raw : FWD_RF;
    bus.StallCnt = rst_n ? stall_cnt_q : '0;
    bus.FlushCnt = rst_n ? flush_cnt_q : '0;
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: a default build plus a 4-bit-counter build
// used to show counter saturation.
module tb_hazard_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hazard_controller_if #(.REG_W(5), .CNT_W(16)) hif ();
  hazard_controller_if #(.REG_W(5), .CNT_W(4))  sif ();

  hazard_controller #(.REG_W(5), .CNT_W(16), .R0_ZERO(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (hif)
  );

  hazard_controller #(.REG_W(5), .CNT_W(4), .R0_ZERO(1'b1)) dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic set_id(input logic [4:0] ra, input logic ua, input logic [4:0] rb,
                        input logic ub, input logic [4:0] rw, input logic wr,
                        input logic ld);
    hif.RaD = ra; hif.UseAD = ua; hif.RbD = rb; hif.UseBD = ub;
    hif.RwD = rw; hif.RegWrD = wr; hif.LoadD = ld;
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) begin
      set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      tick();
    end
  endtask

  task automatic test_reset();
    set_id(5'd3, 1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 1'b1);
    hif.JumpD = 1'b1; hif.BranchTakenE = 1'b1;
    #3;
    checks++; if (hif.FlushID !== 1'b0) begin errors++;
      $display("FAIL rst_flush_id: got %0d want 0", hif.FlushID); end
    checks++; if (hif.FlushIF !== 1'b0 || hif.BubbleE !== 1'b0) begin errors++;
      $display("FAIL rst_flush_if: got %0d/%0d want 0/0", hif.FlushIF, hif.BubbleE); end
    checks++; if (hif.IdValid !== 1'b0 || hif.StallCnt !== 16'd0 || hif.FlushCnt !== 16'd0)
      begin errors++; $display("FAIL rst_state: IdValid=%0d StallCnt=%0d FlushCnt=%0d want 0",
      hif.IdValid, hif.StallCnt, hif.FlushCnt); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    hif.JumpD = 1'b0; hif.BranchTakenE = 1'b0;
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    settle();
    checks++; if (hif.IdValid !== 1'b0) begin errors++;
      $display("FAIL rst_first_cycle: IdValid=%0d want 0", hif.IdValid); end
    tick(); settle();
    checks++; if (hif.IdValid !== 1'b1) begin errors++;
      $display("FAIL rst_second_cycle: IdValid=%0d want 1", hif.IdValid); end
    tick();
  endtask

  task automatic test_independent();
    set_id(5'd2, 1'b1, 5'd3, 1'b1, 5'd1, 1'b1, 1'b0);
    tick();
    set_id(5'd5, 1'b1, 5'd6, 1'b1, 5'd4, 1'b1, 1'b0);
    settle();
    checks++; if (hif.FwdA !== 2'd0 || hif.FwdB !== 2'd0) begin errors++;
      $display("FAIL indep_fwd: FwdA=%0d FwdB=%0d want 0/0", hif.FwdA, hif.FwdB); end
    checks++; if (hif.PcHold !== 1'b0 || hif.IrHold !== 1'b0 || hif.StallCnt !== 16'd0)
      begin errors++; $display("FAIL indep_hold: PcHold=%0d IrHold=%0d StallCnt=%0d want 0",
      hif.PcHold, hif.IrHold, hif.StallCnt); end
    tick();
    drain();
  endtask

  task automatic test_forwarding();
    // Producer ADD R1 followed by SUB R7,R1,R2 at distances 1, 2 and 3.
    for (int gap = 0; gap < 3; gap++) begin
      set_id(5'd2, 1'b1, 5'd3, 1'b1, 5'd1, 1'b1, 1'b0);
      tick();
      for (int j = 0; j < gap; j++) begin
        set_id(5'd10, 1'b1, 5'd11, 1'b1, 5'd9, 1'b1, 1'b0);
        tick();
      end
      set_id(5'd1, 1'b1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0);
      settle();
      checks++; if (hif.FwdA !== 2'(gap + 1) || hif.FwdB !== 2'd0) begin errors++;
        $display("FAIL fwd_gap%0d: FwdA=%0d FwdB=%0d want %0d/0", gap, hif.FwdA, hif.FwdB,
        gap + 1); end
      tick();
      drain();
    end
    // Two writers of R1 in flight: the EX one has priority, via source B.
    set_id(5'd2, 1'b1, 5'd3, 1'b1, 5'd1, 1'b1, 1'b0);
    tick();
    set_id(5'd5, 1'b1, 5'd6, 1'b1, 5'd1, 1'b1, 1'b0);
    tick();
    set_id(5'd1, 1'b0, 5'd1, 1'b1, 5'd8, 1'b1, 1'b0);
    settle();
    checks++; if (hif.FwdB !== 2'd1 || hif.FwdA !== 2'd0) begin errors++;
      $display("FAIL fwd_priority: FwdA=%0d FwdB=%0d want 0/1", hif.FwdA, hif.FwdB); end
    tick();
    drain();
    // Load into R0 followed by a reader of R0: no hazard at all.
    set_id(5'd2, 1'b1, 5'd3, 1'b1, 5'd0, 1'b1, 1'b1);
    tick();
    set_id(5'd0, 1'b1, 5'd0, 1'b1, 5'd4, 1'b1, 1'b0);
    settle();
    checks++; if (hif.PcHold !== 1'b0 || hif.FwdA !== 2'd0 || hif.FwdB !== 2'd0) begin
      errors++; $display("FAIL r0_zero: PcHold=%0d FwdA=%0d FwdB=%0d want 0/0/0",
      hif.PcHold, hif.FwdA, hif.FwdB); end
    tick();
    drain();
  endtask

  task automatic test_load_use();
    set_id(5'd2, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1);
    tick();
    set_id(5'd3, 1'b1, 5'd5, 1'b1, 5'd4, 1'b1, 1'b0);
    settle();
    checks++; if (hif.PcHold !== 1'b1 || hif.IrHold !== 1'b1 || hif.BubbleE !== 1'b1) begin
      errors++; $display("FAIL lu_stall: PcHold=%0d IrHold=%0d BubbleE=%0d want 1/1/1",
      hif.PcHold, hif.IrHold, hif.BubbleE); end
    checks++; if (hif.FwdA !== 2'd0 || hif.FlushIF !== 1'b0) begin errors++;
      $display("FAIL lu_stall_fwd: FwdA=%0d FlushIF=%0d want 0/0", hif.FwdA, hif.FlushIF); end
    tick();
    settle();
    checks++; if (hif.PcHold !== 1'b0 || hif.FwdA !== 2'd2 || hif.IdValid !== 1'b1) begin
      errors++; $display("FAIL lu_release: PcHold=%0d FwdA=%0d IdValid=%0d want 0/2/1",
      hif.PcHold, hif.FwdA, hif.IdValid); end
    checks++; if (hif.StallCnt !== 16'd1) begin errors++;
      $display("FAIL lu_stallcnt: StallCnt=%0d want 1", hif.StallCnt); end
    tick();
    drain();
  endtask

  task automatic test_branch();
    set_id(5'd2, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1);
    tick();
    set_id(5'd3, 1'b1, 5'd5, 1'b1, 5'd4, 1'b1, 1'b0);
    hif.BranchTakenE = 1'b1;
    settle();
    checks++; if (hif.PcHold !== 1'b0 || hif.FlushIF !== 1'b1 || hif.FlushID !== 1'b1 ||
      hif.BubbleE !== 1'b1) begin errors++;
      $display("FAIL br_flush: PcHold=%0d FlushIF=%0d FlushID=%0d BubbleE=%0d want 0/1/1/1",
      hif.PcHold, hif.FlushIF, hif.FlushID, hif.BubbleE); end
    tick();
    hif.BranchTakenE = 1'b0;
    set_id(5'd3, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
    settle();
    checks++; if (hif.IdValid !== 1'b0 || hif.FwdA !== 2'd0) begin errors++;
      $display("FAIL br_killed: IdValid=%0d FwdA=%0d want 0/0", hif.IdValid, hif.FwdA); end
    checks++; if (hif.FlushCnt !== 16'd1 || hif.StallCnt !== 16'd1) begin errors++;
      $display("FAIL br_counts: FlushCnt=%0d StallCnt=%0d want 1/1", hif.FlushCnt,
      hif.StallCnt); end
    tick();
    // The flushed ADD R4 must have left a bubble; the load reaches WB.
    set_id(5'd4, 1'b1, 5'd3, 1'b1, 5'd7, 1'b1, 1'b0);
    settle();
    checks++; if (hif.IdValid !== 1'b1 || hif.FwdA !== 2'd0 || hif.FwdB !== 2'd3) begin
      errors++; $display("FAIL br_bubble: IdValid=%0d FwdA=%0d FwdB=%0d want 1/0/3",
      hif.IdValid, hif.FwdA, hif.FwdB); end
    tick();
    drain();
  endtask

  task automatic test_jump();
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    hif.JumpD = 1'b1;
    settle();
    checks++; if (hif.FlushIF !== 1'b1 || hif.FlushID !== 1'b0 || hif.BubbleE !== 1'b0) begin
      errors++; $display("FAIL jmp_flush: FlushIF=%0d FlushID=%0d BubbleE=%0d want 1/0/0",
      hif.FlushIF, hif.FlushID, hif.BubbleE); end
    tick();
    hif.JumpD = 1'b0;
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);
    settle();
    checks++; if (hif.IdValid !== 1'b0 || hif.FlushCnt !== 16'd2) begin errors++;
      $display("FAIL jmp_shadow: IdValid=%0d FlushCnt=%0d want 0/2", hif.IdValid,
      hif.FlushCnt); end
    tick();
    set_id(5'd8, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
    settle();
    checks++; if (hif.IdValid !== 1'b1 || hif.FwdA !== 2'd0) begin errors++;
      $display("FAIL jmp_ignored_wr: IdValid=%0d FwdA=%0d want 1/0", hif.IdValid, hif.FwdA); end
    tick();
    drain();
    // Jump waiting behind a load-use stall.
    set_id(5'd2, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1);
    tick();
    set_id(5'd3, 1'b1, 5'd5, 1'b1, 5'd4, 1'b1, 1'b0);
    hif.JumpD = 1'b1;
    settle();
    checks++; if (hif.PcHold !== 1'b1 || hif.FlushIF !== 1'b0) begin errors++;
      $display("FAIL jmp_defer: PcHold=%0d FlushIF=%0d want 1/0", hif.PcHold, hif.FlushIF); end
    tick();
    settle();
    checks++; if (hif.PcHold !== 1'b0 || hif.FlushIF !== 1'b1 || hif.StallCnt !== 16'd2) begin
      errors++; $display("FAIL jmp_after_stall: PcHold=%0d FlushIF=%0d StallCnt=%0d want 0/1/2",
      hif.PcHold, hif.FlushIF, hif.StallCnt); end
    tick();
    hif.JumpD = 1'b0;
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    settle();
    checks++; if (hif.IdValid !== 1'b0 || hif.FlushCnt !== 16'd3) begin errors++;
      $display("FAIL jmp_defer_cnt: IdValid=%0d FlushCnt=%0d want 0/3", hif.IdValid,
      hif.FlushCnt); end
    tick();
    drain();
  endtask

  task automatic test_reset_mid_stall();
    set_id(5'd2, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1);
    tick();
    set_id(5'd3, 1'b1, 5'd5, 1'b1, 5'd4, 1'b1, 1'b0);
    settle();
    checks++; if (hif.PcHold !== 1'b1) begin errors++;
      $display("FAIL mid_pre: PcHold=%0d want 1", hif.PcHold); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (hif.PcHold !== 1'b0 || hif.BubbleE !== 1'b0 || hif.IdValid !== 1'b0) begin
      errors++; $display("FAIL mid_rst_out: PcHold=%0d BubbleE=%0d IdValid=%0d want 0/0/0",
      hif.PcHold, hif.BubbleE, hif.IdValid); end
    checks++; if (hif.StallCnt !== 16'd0 || hif.FlushCnt !== 16'd0) begin errors++;
      $display("FAIL mid_rst_cnt: StallCnt=%0d FlushCnt=%0d want 0/0", hif.StallCnt,
      hif.FlushCnt); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    settle();
    checks++; if (hif.IdValid !== 1'b0) begin errors++;
      $display("FAIL mid_release0: IdValid=%0d want 0", hif.IdValid); end
    tick(); settle();
    checks++; if (hif.IdValid !== 1'b1) begin errors++;
      $display("FAIL mid_release1: IdValid=%0d want 1", hif.IdValid); end
  endtask

  task automatic test_saturation();
    // LW R3,(R3) held in ID: stalls on every second cycle, so floor(t/2) stalls after t edges.
    tick();
    sif.RaD = 5'd3; sif.UseAD = 1'b1; sif.RwD = 5'd3; sif.RegWrD = 1'b1; sif.LoadD = 1'b1;
    repeat (10) tick();
    checks++; if (sif.StallCnt !== 4'd5) begin errors++;
      $display("FAIL sat_10: StallCnt=%0d want 5", sif.StallCnt); end
    repeat (19) tick();
    checks++; if (sif.StallCnt !== 4'd14) begin errors++;
      $display("FAIL sat_29: StallCnt=%0d want 14", sif.StallCnt); end
    tick();
    checks++; if (sif.StallCnt !== 4'd15) begin errors++;
      $display("FAIL sat_30: StallCnt=%0d want 15", sif.StallCnt); end
    repeat (10) tick();
    checks++; if (sif.StallCnt !== 4'd15) begin errors++;
      $display("FAIL sat_hold: StallCnt=%0d want 15", sif.StallCnt); end
  endtask

  initial begin
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    hif.JumpD = 1'b0; hif.BranchTakenE = 1'b0;
    sif.RaD = '0; sif.RbD = '0; sif.UseAD = 1'b0; sif.UseBD = 1'b0; sif.RwD = '0;
    sif.RegWrD = 1'b0; sif.LoadD = 1'b0; sif.JumpD = 1'b0; sif.BranchTakenE = 1'b0;
    test_reset();
    test_independent();
    test_forwarding();
    test_load_use();
    test_branch();
    test_jump();
    test_reset_mid_stall();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Pipeline sequencing controller for the 5-stage CPU (IF, ID, EX, MEM, WB).
- Tracks in-flight destination registers in EX/MEM/WB and drives decode-stage operand forwarding selects.
- Stalls IF/ID and inserts an EX bubble on load-use hazards.
- Flushes wrong-path instructions on control transfers; keeps saturating stall/flush counters.

Parameters:
REG_W, 5, register-address width
CNT_W, 16, performance-counter width
R0_ZERO, 1, when 1 register 0 never matches (no forward, no stall)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
RaD  in  REG_W  decode source A (rs1)
RbD  in  REG_W  decode source B (rb mux output)
UseAD  in  1  decode instruction reads A
UseBD  in  1  decode instruction reads B
RwD  in  REG_W  decode destination (rd)
RegWrD  in  1  decode instruction writes a register
LoadD  in  1  decode instruction is a load (MemRd)
JumpD  in  1  jump/call/return resolved in ID
BranchTakenE  in  1  branch in EX resolved taken
IdValid  out  1  ID instruction is live; decoder gates RegWr/MemWr/Stack writes with it
PcHold  out  1  hold PC this cycle
IrHold  out  1  hold IF/ID buffers this cycle
BubbleE  out  1  load NOP into ID/EX
FlushIF  out  1  kill instruction being fetched
FlushID  out  1  kill instruction in ID
FwdA  out  2  0 register file, 1 ALU result (EX), 2 MEM result mux, 3 WB buffer
FwdB  out  2  same encoding for source B
StallCnt  out  CNT_W  load-use stall cycles
FlushCnt  out  CNT_W  flush events

Behaviour:
- State registers:
  - id_vld.
  - Three stage entries ex_q, mem_q, wb_q, each {vld, rd, wr, ld}.
  - Two counters.
- Reset (rst_n low, asynchronous):
  - All vld bits, id_vld and both counters are 0.
  - All outputs are forced 0 while rst_n is low.
- match(e, r): e.vld & e.wr & e.rd==r & !(R0_ZERO & r==0).
- LoadUse: IdValid & ex_q.ld & ((UseAD & match(ex_q,RaD)) | (UseBD & match(ex_q,RbD))).
- Stall = LoadUse & !BranchTakenE. PcHold = IrHold = Stall.
- FlushID = BranchTakenE.
- FlushIF = BranchTakenE | (IdValid & JumpD & !Stall).
- BubbleE = Stall | FlushID.
- Fwd per source:
  - Priority is EX(1) > MEM(2) > WB(3) > RF(0), each gated by the Use bit.
  - Fwd = 0 when Stall or !IdValid.
- Stage entries update every rising edge:
  - wb_q <= mem_q; mem_q <= ex_q.
  - ex_q <= BubbleE ? invalid : {IdValid, RwD, RegWrD, LoadD}.
- id_vld next value:
  - Stall: hold.
  - FlushIF: 0.
  - Otherwise: 1.
  - The first fetch after reset becomes valid one cycle after rst_n deasserts.
- Latency:
  - All hazard outputs are combinational in the same cycle as their inputs.
  - Stall lasts exactly 1 cycle per load-use: the load moves to MEM, then the MEM forward covers the operand.
- Simultaneous events:
  - BranchTakenE beats LoadUse: no stall; ID and IF are flushed.
  - JumpD during Stall is deferred until the stall clears.
- Counters:
  - StallCnt +1 on each Stall cycle.
  - FlushCnt +1 on each cycle with FlushIF.
  - Both saturate at all-ones; no wrap.
- Register writeback occurs at WB, so an instruction reading the WB destination uses FwdA/FwdB=3.

Decomposition:
- Shared package pipe_pkg holds:
  - stage_entry_t {vld, rd[REG_W], wr, ld}.
  - Forward-select constants FWD_RF=0, FWD_EX=1, FWD_MEM=2, FWD_WB=3.
- One natural sub-module: fwd_select.
  - Combinational priority compare of one source register against ex_q/mem_q/wb_q.
  - Instantiated twice, for A and B.
- Counters stay inline.

Test Plan:
- Independent instructions, e.g. ADD R1,R2,R3 then ADD R4,R5,R6 -> FwdA=FwdB=0, no hold, StallCnt stays 0.
- ALU back-to-back: ADD R1 then SUB R7,R1,R2 -> FwdA=1 in the SUB decode cycle. With one unrelated instruction between -> FwdA=2. With two between -> FwdA=3.
- Load-use: LW R3 then ADD R4,R3,R5:
  - Cycle 1: PcHold=IrHold=BubbleE=1.
  - Next cycle: FwdA=2, Stall=0, StallCnt=1.
- Branch taken: BranchTakenE=1 in the same cycle as a load-use match -> Stall=0, FlushIF=FlushID=1, ex_q bubble, id_vld 0 next cycle, FlushCnt=1.
- Jump in ID: JumpD=1 with IdValid=1 -> FlushIF=1, FlushID=0. The following fetch has IdValid=0 and its RegWrD is ignored (ex_q.vld=0).
- Reset and saturation:
  - Assert rst_n low mid-stall -> outputs 0 immediately; after release IdValid=0 for 1 cycle.
  - Preload StallCnt near the maximum (CNT_W=4 build) -> holds at 15.
